alu_seq_iter: RTL and testbench

//  Parametrised, handshaked successor of the 16-bit combinational ALU: same op set
//  (AND, OR, XOR, ADD/SUB, ADDI/SUBI, SLT, SLL, SRA), generic width, registered result.

---
 rtl/alu_seq_iter_if.sv | 30 +++
 rtl/alu_seq_iter.sv | 142 ++++++++++++++
 tb/tb_alu_seq_iter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_iter_if.sv
// Request/response bundle for alu_seq_iter: operand request channel plus the
// registered result channel, each under valid/ready flow control.
interface alu_seq_iter_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_invert;
  logic [2:0]       alu_op;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, a, b, b_invert, alu_op, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow, carry_out
  );

  modport slave (
    input  in_valid, a, b, b_invert, alu_op, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_seq_iter.sv
// Handshaked ALU with registered result; shifts iterate one bit per cycle unless
// ALU_BARREL_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_seq_iter #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_seq_iter_if.slave alu_io
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             carry_q;
  logic             out_valid_q;
`ifndef ALU_BARREL_SHIFT_EN
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic             sra_q;
  logic [WIDTH-1:0] work_d;
`endif

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             slt_bit;
  logic [WIDTH-1:0] op_result;
  logic             op_ovf;
  logic             op_carry;

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & alu_io.out_ready);
  assign accept   = alu_io.in_valid & in_ready;

  always_comb begin
    b_eff   = alu_io.b_invert ? ~alu_io.b : alu_io.b;
    sum     = {1'b0, alu_io.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, alu_io.b_invert};
    add_ovf = (alu_io.a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != alu_io.a[WIDTH-1]);
    // SLT always subtracts, independent of BInvert
    diff    = alu_io.a + ~alu_io.b + {{(WIDTH-1){1'b0}}, 1'b1};
    slt_bit = diff[WIDTH-1] ^ ((alu_io.a[WIDTH-1] != alu_io.b[WIDTH-1]) &
                               (diff[WIDTH-1] != alu_io.a[WIDTH-1]));
    op_result = '0;
    op_ovf    = 1'b0;
    op_carry  = 1'b0;
    case (alu_io.alu_op)
      3'b000: op_result = alu_io.a & alu_io.b;
      3'b001: op_result = {{(WIDTH-1){1'b0}}, slt_bit};
      3'b010: op_result = alu_io.a | alu_io.b;
      3'b011: op_result = alu_io.a ^ alu_io.b;
      3'b100, 3'b101: begin
        op_result = sum[WIDTH-1:0];
        op_ovf    = add_ovf;
        op_carry  = sum[WIDTH];
      end
`ifdef ALU_BARREL_SHIFT_EN
      3'b110: op_result = alu_io.a << alu_io.shamt;
      3'b111: op_result = $signed(alu_io.a) >>> alu_io.shamt;
`else
      // Only reached for a zero shift amount; non-zero shifts go through SHIFT
      3'b110, 3'b111: op_result = alu_io.a;
`endif
      default: op_result = '0;
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  always_comb begin
    work_d = sra_q ? {work_q[WIDTH-1], work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      work_q      <= '0;
      cnt_q       <= '0;
      sra_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
            if ((alu_io.alu_op[2:1] == 2'b11) && (alu_io.shamt != '0)) begin
              work_q      <= alu_io.a;
              cnt_q       <= alu_io.shamt;
              sra_q       <= alu_io.alu_op[0];
              out_valid_q <= 1'b0;
              state_q     <= SHIFT;
            end else
`endif
            begin
              result_q    <= op_result;
              zero_q      <= (op_result == '0);
              overflow_q  <= op_ovf;
              carry_q     <= op_carry;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end else if ((state_q == DONE) && alu_io.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_q    <= work_d;
            zero_q      <= (work_d == '0);
            overflow_q  <= 1'b0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_io.in_ready  = in_ready;
  assign alu_io.out_valid = out_valid_q;
  assign alu_io.result    = result_q;
  assign alu_io.zero      = zero_q;
  assign alu_io.overflow  = overflow_q;
  assign alu_io.carry_out = carry_q;
endmodule

// File: tb/tb_alu_seq_iter.sv
// Bench for alu_seq_iter (WIDTH=16): directed vectors with literal expectations plus
// a scoreboard of model-predicted results checked every cycle OutValid is high.
module tb_alu_seq_iter;
  localparam int W  = 16;
  localparam int SW = 4;
`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_iter_if #(.WIDTH(W), .SHW(SW)) bus ();
  alu_seq_iter #(.WIDTH(W), .SHW(SW)) dut (.clk_i(clk), .rst_i(rst), .alu_io(bus));

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [2:0]  zoc;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   head_seen = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference behaviour from plain signed/unsigned arithmetic
  function automatic exp_t model(input string name, input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic binv, input logic [3:0] sh);
    exp_t e;
    logic [15:0] bp;
    logic [16:0] s;
    int ideal;
    logic z, o, c;
    e.name = name; e.res = '0; e.lat = 1; e.acc = 0;
    o = 1'b0; c = 1'b0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd2: e.res = a | b;
      3'd3: e.res = a ^ b;
      3'd4, 3'd5: begin
        bp    = binv ? ~b : b;
        s     = {1'b0, a} + {1'b0, bp} + 17'(binv);
        e.res = s[15:0];
        c     = s[16];
        ideal = int'($signed(a)) + int'($signed(bp)) + int'(binv);
        o     = (ideal > 32767) || (ideal < -32768);
      end
      3'd6: begin e.res = a << sh;          if (!BARREL) e.lat = 1 + int'(sh); end
      default: begin e.res = $signed(a) >>> sh; if (!BARREL) e.lat = 1 + int'(sh); end
    endcase
    z = (e.res == 16'd0);
    e.zoc = {z, o, c};
    return e;
  endfunction

  // Scoreboard compare, sampled mid-low-phase after the driver has settled
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (q.size() > 0 && cyc >= q[0].acc) begin
        if (bus.out_valid) begin
          check({q[0].name, " sb result"}, bus.result, q[0].res);
          check({q[0].name, " sb flags"}, {bus.zero, bus.overflow, bus.carry_out}, q[0].zoc);
          if (head_seen == 0) begin
            check({q[0].name, " sb latency"}, cyc - q[0].acc + 1, q[0].lat);
            head_seen = 1;
          end
          if (bus.out_ready) begin
            void'(q.pop_front());
            head_seen = 0;
          end
        end else if (head_seen != 0 || (cyc - q[0].acc + 1) > q[0].lat) begin
          n_tests++; n_fail++;
          $display("FAIL %s sb out_valid: got 0 required 1 (cycle %0d)", q[0].name, cyc - q[0].acc + 1);
          void'(q.pop_front());
          head_seen = 0;
        end
      end else if (bus.out_valid) begin
        n_tests++; n_fail++;
        $display("FAIL sb spurious out_valid: got 1 required 0");
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accept edge
  task automatic send(input string name, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic binv, input logic [3:0] sh);
    exp_t e;
    bit ok = 0;
    bus.in_valid = 1'b1; bus.alu_op = op; bus.a = a; bus.b = b;
    bus.b_invert = binv; bus.shamt = sh;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (bus.in_ready) begin
        e = model(name, op, a, b, binv, sh);
        e.acc = cyc + 1;
        last_acc = e.acc;
        q.push_back(e);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s accept: in_ready got 0 required 1", name);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [15:0] res, input logic [2:0] zoc,
                             input int lat);
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      #3;
      if (bus.out_valid) begin
        got = 1;
        check({name, " result"}, bus.result, res);
        check({name, " flags"}, {bus.zero, bus.overflow, bus.carry_out}, zoc);
        check({name, " latency"}, cyc - last_acc + 1, lat);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s out_valid: got 0 required 1 (timeout)", name);
    end
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic binv, input logic [3:0] sh,
                     input logic [15:0] res, input logic [2:0] zoc, input int lat);
    send(name, op, a, b, binv, sh);
    wait_result(name, res, zoc, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.b_invert = 1'b0;
    bus.alu_op = '0; bus.shamt = '0; bus.out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    check("reset result", bus.result, 16'h0);
    check("reset flags", {bus.zero, bus.overflow, bus.carry_out}, 3'b000);
    check("reset out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // flags are {zero, overflow, carry}
    run("and",      3'd0, 16'd10,    16'd15,    1'b0, 4'd0,  16'd10,    3'b000, 1);
    run("or",       3'd2, 16'd11,    16'd14,    1'b0, 4'd0,  16'd15,    3'b000, 1);
    run("xor",      3'd3, 16'd12,    16'd14,    1'b0, 4'd0,  16'd2,     3'b000, 1);
    run("sub",      3'd4, 16'd14,    16'd12,    1'b1, 4'd0,  16'd2,     3'b001, 1);
    run("add_ovf",  3'd4, 16'h7FFF,  16'd1,     1'b0, 4'd0,  16'h8000,  3'b010, 1);
    run("sub_zero", 3'd4, 16'd5,     16'd5,     1'b1, 4'd0,  16'd0,     3'b101, 1);
    run("subi_brw", 3'd5, 16'd0,     16'd1,     1'b1, 4'd0,  16'hFFFF,  3'b000, 1);
    run("add_cry",  3'd4, 16'hFFFF,  16'd1,     1'b0, 4'd0,  16'd0,     3'b101, 1);
    run("sra3",     3'd7, 16'h8008,  16'd0,     1'b0, 4'd3,  16'hF001,  3'b000, BARREL ? 1 : 4);
    run("sll1",     3'd6, 16'd12,    16'd0,     1'b0, 4'd1,  16'd24,    3'b000, BARREL ? 1 : 2);
    run("sll0",     3'd6, 16'd12,    16'd0,     1'b0, 4'd0,  16'd12,    3'b000, 1);
    run("sra15",    3'd7, 16'h7000,  16'd0,     1'b0, 4'd15, 16'd0,     3'b100, BARREL ? 1 : 16);
    run("sll15",    3'd6, 16'd1,     16'd0,     1'b0, 4'd15, 16'h8000,  3'b000, BARREL ? 1 : 16);
    run("slt_0_1",  3'd1, 16'd0,     16'd1,     1'b0, 4'd0,  16'd1,     3'b000, 1);
    run("slt_m1_0", 3'd1, 16'hFFFF,  16'd0,     1'b0, 4'd0,  16'd1,     3'b000, 1);
    run("slt_1_0",  3'd1, 16'd1,     16'd0,     1'b0, 4'd0,  16'd0,     3'b100, 1);
    run("slt_min",  3'd1, 16'h8000,  16'h7FFF,  1'b0, 4'd0,  16'd1,     3'b000, 1);
    run("slt_binv", 3'd1, 16'd0,     16'd1,     1'b1, 4'd0,  16'd1,     3'b000, 1);

    // Back-pressure: result held while a pending request waits
    bus.out_ready = 1'b0;
    run("hold_and", 3'd0, 16'h00F0, 16'h0FF0, 1'b0, 4'd0, 16'h00F0, 3'b000, 1);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.alu_op = 3'd4; bus.a = 16'd100; bus.b = 16'd23;
      bus.b_invert = 1'b0; bus.shamt = 4'd0;
      #3;
      check("hold result", bus.result, 16'h00F0);
      check("hold out_valid", bus.out_valid, 1'b1);
      check("hold in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    run("b2b_add", 3'd4, 16'd100, 16'd23, 1'b0, 4'd0, 16'd123, 3'b000, 1);

    // Reset in the middle of a long shift
    send("rst_sll", 3'd6, 16'd1, 16'd0, 1'b0, 4'd15);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    q.delete();
    head_seen = 0;
    #1;
    check("midrst result", bus.result, 16'h0);
    check("midrst flags", {bus.zero, bus.overflow, bus.carry_out}, 3'b000);
    check("midrst out_valid", bus.out_valid, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    run("post_rst_add", 3'd4, 16'd3, 16'd4, 1'b0, 4'd0, 16'd7, 3'b000, 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
